// File: rtl/fifo_status.sv
// fifo_status: single-clock show-ahead FIFO with level, almost-full/empty
// thresholds and sticky overflow/underflow flags.
//
// Handshake: a push is accepted on a rising edge when push && (!full || pop);
// a pop is accepted when pop && !empty. There is no back-pressure stall: a
// push that is not accepted is dropped and recorded in overflow, and a pop that
// is not accepted is ignored and recorded in underflow. read_data always shows
// the head word, and pop acknowledges that word.
module fifo_status #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         write_data,
  input  logic                     flush,
  input  logic                     clear_err,
  output logic [WIDTH-1:0]         read_data,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_full;
  logic             w_empty;
  logic             w_push_acc;
  logic             w_pop_acc;
  logic             w_ovf_set;
  logic             w_unf_set;
  logic             w_clear_all;

  // Pointer compare: same index with differing wrap bit means full.
  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // A pop frees a slot in the same edge, so a full FIFO still takes a push
  // when it is paired with a pop.
  assign w_push_acc  = push && (!w_full || pop);
  assign w_pop_acc   = pop && !w_empty;
  assign w_ovf_set   = push && w_full && !pop;
  assign w_unf_set   = pop && w_empty;
  assign w_clear_all = rst || flush;

  // Storage write; never reset, and suppressed by rst/flush so a discarded
  // push cannot leave a stale word behind.
  always_ff @(posedge clk) begin
    if (w_push_acc && !w_clear_all) begin
      r_mem[r_wr_ptr[AW-1:0]] <= write_data;
    end
  end

  // Pointer and level tracking; rst and flush both return to the empty state.
  always_ff @(posedge clk) begin
    if (w_clear_all) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_acc)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_acc, w_pop_acc})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Sticky error flags; a new event wins over clear_err in the same cycle.
  always_ff @(posedge clk) begin
    if (w_clear_all) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_ovf_set)      r_overflow <= 1'b1;
      else if (clear_err) r_overflow <= 1'b0;
      if (w_unf_set)      r_underflow <= 1'b1;
      else if (clear_err) r_underflow <= 1'b0;
    end
  end

  assign read_data    = r_mem[r_rd_ptr[AW-1:0]];
  assign empty        = w_empty;
  assign full         = w_full;
  assign level        = r_level;
  assign almost_full  = (r_level >= LW'(AF_LEVEL));
  assign almost_empty = (r_level <= LW'(AE_LEVEL));
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule
